// File: rtl/lelo_osc_pkg.sv
// Shared definitions for the oscillator frequency meter: FSM states,
// settle length and default parameter values.
package lelo_osc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_GATE,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam int SETTLE_LEN = 3;

  localparam int DEF_NCH   = 2;
  localparam int DEF_CNT_W = 11;
  localparam int DEF_WIN_W = 16;

endpackage

// File: rtl/lelo_osc_chan.sv
// One measurement channel: synchroniser, rising-edge detector,
// saturating window counter with sticky overflow, and window accumulator.
module lelo_osc_chan #(
  parameter int CNT_W = 11,
  parameter int ACC_W = CNT_W + 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             osc,
  input  logic             clear,
  input  logic             count_en,
  input  logic             accum,
  output logic [ACC_W-1:0] acc_sum,
  output logic             ovf
);

  logic [2:0]       sync;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;

  // sync[1:0] are the metastability flops, sync[2] holds the previous sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[1:0], osc};
  end

  assign rise    = sync[1] & ~sync[2];
  assign acc_sum = acc + ACC_W'(cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      if (count_en && rise) begin
        if (cnt == '1) ovf <= 1'b1;
        else           cnt <= cnt + CNT_W'(1);
      end
      if (accum) begin
        acc <= acc_sum;
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lelo_osc_meas.sv
// Multi-channel oscillator frequency meter with a shared gate window and
// power-of-two averaging. Optional alarm outputs under LELO_OSC_ALARM_EN.
module lelo_osc_meas
  import lelo_osc_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W,
  parameter int ACC_W = CNT_W + 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       osc_in,
  input  logic                 start,
  input  logic [WIN_W-1:0]     win_len,
  input  logic [1:0]           avg_log2,
`ifdef LELO_OSC_ALARM_EN
  input  logic [CNT_W-1:0]     thr_hi,
  input  logic [CNT_W-1:0]     thr_lo,
  output logic [NCH-1:0]       alarm,
`endif
  output logic                 busy,
  output logic                 valid,
  output logic [NCH*CNT_W-1:0] result,
  output logic [NCH-1:0]       ovf
);

  state_t           state, state_nxt;
  logic [WIN_W-1:0] win_q, tmr;
  logic [1:0]       avg_q;
  logic [3:0]       win_cnt;
  logic             last_win, meas_start, finish;
  logic [NCH-1:0]   ovf_ch;
  logic [CNT_W-1:0] res_nxt [NCH];

  assign meas_start = (state == S_IDLE) && start;
  assign last_win   = 4'(win_cnt + 4'd1) == (4'd1 << avg_q);
  assign finish     = (state == S_ACCUM) && last_win;
  assign busy       = (state != S_IDLE);
  assign valid      = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: if (tmr == WIN_W'(1)) state_nxt = S_GATE;
      S_GATE:   if (tmr == WIN_W'(1)) state_nxt = S_ACCUM;
      S_ACCUM:  state_nxt = last_win ? S_DONE : S_GATE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // tmr counts down the current SETTLE or GATE phase; a zero window length runs as one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q   <= '0;
      avg_q   <= '0;
      tmr     <= '0;
      win_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          win_q   <= (win_len == '0) ? WIN_W'(1) : win_len;
          avg_q   <= avg_log2;
          tmr     <= WIN_W'(SETTLE_LEN);
          win_cnt <= '0;
        end
        S_SETTLE: tmr <= (tmr == WIN_W'(1)) ? win_q : tmr - WIN_W'(1);
        S_GATE:   tmr <= tmr - WIN_W'(1);
        S_ACCUM: begin
          tmr     <= win_q;
          win_cnt <= win_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [ACC_W-1:0] acc_sum, shifted;

    lelo_osc_chan #(.CNT_W(CNT_W), .ACC_W(ACC_W)) u_chan (
      .clk      (clk),
      .reset    (reset),
      .osc      (osc_in[g]),
      .clear    (meas_start),
      .count_en (state == S_GATE),
      .accum    (state == S_ACCUM),
      .acc_sum  (acc_sum),
      .ovf      (ovf_ch[g])
    );

    assign shifted    = acc_sum >> avg_q;
    assign res_nxt[g] = (|(shifted >> CNT_W)) ? '1 : shifted[CNT_W-1:0];
  end

  // Outputs load on the edge into DONE so they are already valid during the DONE cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      ovf    <= '0;
    end else if (finish) begin
      for (int i = 0; i < NCH; i++) result[i*CNT_W +: CNT_W] <= res_nxt[i];
      ovf <= ovf_ch;
    end
  end

`ifdef LELO_OSC_ALARM_EN
  logic [CNT_W-1:0] thr_hi_q, thr_lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_hi_q <= '0;
      thr_lo_q <= '0;
      alarm    <= '0;
    end else begin
      if (meas_start) begin
        thr_hi_q <= thr_hi;
        thr_lo_q <= thr_lo;
      end
      if (finish) begin
        for (int i = 0; i < NCH; i++)
          alarm[i] <= (res_nxt[i] > thr_hi_q) || (res_nxt[i] < thr_lo_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_lelo_osc_meas.sv
// Self-checking bench for lelo_osc_meas: directed scenarios plus randomized
// runs, each compared with a nominal-frequency model (count = window * f_osc / f_clk).
`timescale 1ns/1ps
module tb_lelo_osc_meas;

  localparam int NCH   = 2;
  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [NCH-1:0]       osc_in = '0;
  logic [WIN_W-1:0]     win_len = '0;
  logic [1:0]           avg_log2 = '0;
  logic                 busy, valid;
  logic [NCH*CNT_W-1:0] result;
  logic [NCH-1:0]       ovf;
`ifdef LELO_OSC_ALARM_EN
  logic [CNT_W-1:0]     thr_hi = '0;
  logic [CNT_W-1:0]     thr_lo = '0;
  logic [NCH-1:0]       alarm;
`endif

  int      checks = 0;
  int      failures = 0;
  realtime half0 = 50.0;
  realtime half1 = 50.0;

  lelo_osc_meas #(.NCH(NCH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .osc_in   (osc_in),
    .start    (start),
    .win_len  (win_len),
    .avg_log2 (avg_log2),
`ifdef LELO_OSC_ALARM_EN
    .thr_hi   (thr_hi),
    .thr_lo   (thr_lo),
    .alarm    (alarm),
`endif
    .busy     (busy),
    .valid    (valid),
    .result   (result),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Oscillator edges sit 0.37 ns off any half-ns grid, so they never coincide with a clock edge
  initial begin
    #(0.37 + $urandom_range(0, 30));
    forever begin osc_in[0] = ~osc_in[0]; #(half0); end
  end
  initial begin
    #(1.87 + $urandom_range(0, 30));
    forever begin osc_in[1] = ~osc_in[1]; #(half1); end
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp, input int tol = 0);
    checks++;
    if (obs < exp - tol || obs > exp + tol) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic applyStimulus(input string tag, input int w, input int avg, input int p0,
                               input int p1, input int thi, input int tlo);
    int  weff, nwin, kexp, k, busy_cnt, valid_k;
    int  exp_r [NCH];
    int  tol [NCH];
    int  exp_o [NCH];
    int  per [NCH];
    real nom;
    per[0] = p0;
    per[1] = p1;
    weff = (w == 0) ? 1 : w;
    nwin = 1 << avg;
    kexp = 4 + nwin * (weff + 1);
    for (int ch = 0; ch < NCH; ch++) begin
      nom = weff * 10.0 / per[ch];
      if (nom > MAXC) begin
        exp_r[ch] = MAXC; tol[ch] = 0; exp_o[ch] = 1;
      end else begin
        exp_r[ch] = int'(nom); tol[ch] = 1; exp_o[ch] = 0;
      end
    end

    for (int i = 0; i < 30000 && busy; i++) @(negedge clk);
    checkOutput({tag, "/idle_before"}, int'(busy), 0);
    half0 = p0 / 2.0;
    half1 = p1 / 2.0;
    repeat (40) @(negedge clk);

    win_len  = WIN_W'(w);
    avg_log2 = 2'(avg);
`ifdef LELO_OSC_ALARM_EN
    thr_hi = CNT_W'(thi);
    thr_lo = CNT_W'(tlo);
`endif
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    win_len  = WIN_W'($urandom);
    avg_log2 = 2'($urandom);
`ifdef LELO_OSC_ALARM_EN
    thr_hi = CNT_W'($urandom);
    thr_lo = CNT_W'($urandom);
`endif

    // A start pulse inside the measurement must not disturb it
    k = 1; busy_cnt = 0; valid_k = 0;
    while (k <= kexp + 20 && valid_k == 0) begin
      if (busy) busy_cnt++;
      if (valid) valid_k = k;
      else begin
        if (k == 3) start = 1'b1;
        else if (k == 4) start = 1'b0;
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    checkOutput({tag, "/valid_cycle"}, valid_k, kexp);
    if (valid_k == 0) return;
    checkOutput({tag, "/busy_cycles"}, busy_cnt, kexp);

    for (int ch = 0; ch < NCH; ch++) begin
      checkOutput($sformatf("%s/result%0d", tag, ch), int'(result[ch*CNT_W +: CNT_W]), exp_r[ch], tol[ch]);
      checkOutput($sformatf("%s/ovf%0d", tag, ch), int'(ovf[ch]), exp_o[ch]);
`ifdef LELO_OSC_ALARM_EN
      if (exp_r[ch] - tol[ch] > thi || exp_r[ch] + tol[ch] < tlo)
        checkOutput($sformatf("%s/alarm%0d", tag, ch), int'(alarm[ch]), 1);
      else if (exp_r[ch] + tol[ch] <= thi && exp_r[ch] - tol[ch] >= tlo)
        checkOutput($sformatf("%s/alarm%0d", tag, ch), int'(alarm[ch]), 0);
`endif
    end

    // Start during DONE is ignored and valid is a single-cycle pulse
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "/done_start_busy"}, int'(busy), 0);
    checkOutput({tag, "/valid_pulse"}, int'(valid), 0);

    repeat (10) @(negedge clk);
    checkOutput({tag, "/hold_result0"}, int'(result[CNT_W-1:0]), exp_r[0], tol[0]);
    checkOutput({tag, "/hold_ovf0"}, int'(ovf[0]), exp_o[0]);
  endtask

  initial begin
    int w, avg, p0, p1;
    real n0, n1;

    #3;
    checkOutput("reset/busy", int'(busy), 0);
    checkOutput("reset/valid", int'(valid), 0);
    checkOutput("reset/result", int'(result), 0);
    checkOutput("reset/ovf", int'(ovf), 0);
`ifdef LELO_OSC_ALARM_EN
    checkOutput("reset/alarm", int'(alarm), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    applyStimulus("a",  1000, 0, 100, 100, 90, 10);
    applyStimulus("b",  500,  0, 200, 50,  90, 10);
    applyStimulus("c",  100,  2, 100, 100, 90, 10);
    applyStimulus("d",  1000, 0, 25,  100, 90, 10);
    applyStimulus("d2", 1000, 0, 100, 100, 90, 10);

    // Reset in the middle of a gate window clears everything at once
    win_len = WIN_W'(200); avg_log2 = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("e/busy", int'(busy), 0);
    checkOutput("e/result", int'(result), 0);
    checkOutput("e/ovf", int'(ovf), 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("e2", 300, 1, 100, 60, 90, 10);

    applyStimulus("f", 0, 0, 100, 100, 90, 10);

    for (int r = 0; r < 6; r++) begin
      do begin
        w  = $urandom_range(1, 300);
        p0 = $urandom_range(23, 300);
        p1 = $urandom_range(23, 300);
        n0 = w * 10.0 / p0;
        n1 = w * 10.0 / p1;
      end while ((n0 >= 250.0 && n0 <= 262.0) || (n1 >= 250.0 && n1 <= 262.0));
      avg = $urandom_range(0, 3);
      applyStimulus($sformatf("rnd%0d", r), w, avg, p0, p1,
                    $urandom_range(0, MAXC), $urandom_range(0, MAXC));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lelo_osc_meas.md
LELO_OSC_MEAS -- requirements
Module: lelo_osc_meas

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
  NCH, 2, number of oscillator channels;
  CNT_W, 11, result width per channel;
  WIN_W, 16, gate-window length register width;
  ACC_W, CNT_W+4, accumulator width.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk  input  1  system clock, the only clock;
  reset  input  1  asynchronous, active-high reset;
  osc_in  input  NCH  raw oscillator outputs, asynchronous to clk;
  start  input  1  single-cycle measurement request;
  win_len  input  WIN_W  gate length in clk cycles (0 treated as 1);
  avg_log2  input  2  average over 2^avg_log2 windows;
  busy  output  1  measurement in progress;
  valid  output  1  one-cycle pulse, results updated;
  result  output  NCH*CNT_W  averaged count, channel 0 in the LSBs;
  ovf  output  NCH  per-channel saturation flag for the last measurement.

Function
REQ-003 Each osc_in bit SHALL pass a 2-flop synchroniser, then a rising-edge detector (third flop); the count is valid only while f_osc < f_clk/2.
REQ-004 The FSM SHALL have states IDLE, SETTLE, GATE, ACCUM and DONE.
REQ-005 IDLE -> SETTLE on start; win_len and avg_log2 SHALL be latched on that cycle and held until DONE.
REQ-006 SETTLE SHALL last exactly 3 cycles to flush the synchronisers; no edges are counted there.
REQ-007 GATE SHALL last exactly max(win_len,1) cycles; one edge-detect pulse in GATE SHALL increment that channel's window counter by 1.
REQ-008 A window counter SHALL saturate at 2^CNT_W-1 and set that channel's sticky overflow bit for the current measurement.
REQ-009 ACCUM (1 cycle) SHALL add each window count into the ACC_W accumulator and clear the window counters.
REQ-010 From ACCUM the FSM SHALL re-enter GATE with no SETTLE until 2^avg_log2 windows are done, then go to DONE.
REQ-011 In DONE (1 cycle), result SHALL equal accumulator >> avg_log2, truncated and saturated to CNT_W; ovf SHALL be updated; valid=1; next state IDLE.
REQ-012 busy SHALL be 1 in every state except IDLE.
REQ-013 start while busy SHALL be ignored; start in the DONE cycle SHALL also be ignored.
REQ-014 result and ovf SHALL hold their values between valid pulses.
REQ-015 All channels SHALL share one gate and be measured simultaneously.

Reset
REQ-016 Asserting reset at any time, including mid-measurement, SHALL immediately force IDLE and clear counters, accumulators and synchronisers.
REQ-017 The reset values of the outputs SHALL be busy=0, valid=0, result=0, ovf=0.

Configuration
REQ-018 With LELO_OSC_ALARM_EN defined, the block SHALL add inputs thr_hi and thr_lo (CNT_W each, latched at start) and output alarm (NCH bits).
REQ-019 In that configuration, in DONE, alarm[i] SHALL be set to (result_i > thr_hi) || (result_i < thr_lo) and held until the next DONE; its reset value SHALL be 0.
REQ-020 Without LELO_OSC_ALARM_EN, these ports and their logic SHALL be absent.

Structure
REQ-021 The package lelo_osc_pkg SHALL hold the FSM state enum, the SETTLE length constant (3) and the default parameter values.
REQ-022 The per-channel synchroniser, edge detector, saturating counter and accumulator SHALL be one sub-module, lelo_osc_chan, instantiated NCH times with generate.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  a) clk 100 MHz, osc0 = 10 MHz, win_len=1000, avg_log2=0, start -> valid after 1000+3+1+1 cycles from the start cycle; result0 = 100 +/- 1.
  b) NCH=2, osc0 = 5 MHz, osc1 = 20 MHz, win_len=500 -> result0 = 25 +/- 1, result1 = 100 +/- 1, one common valid pulse.
  c) avg_log2=2, win_len=100, osc = 10 MHz -> four GATE windows; result = 10 +/- 1; busy high for 3+4*(100+1)+1 cycles.
  d) CNT_W=8, osc = 40 MHz, win_len=1000 -> result = 255, ovf0 = 1; a following unsaturated run clears ovf0.
  e) reset asserted mid-GATE -> busy=0 and result=0 in the same cycle; a new start gives a correct result.
  f) LELO_OSC_ALARM_EN, thr_hi=90, thr_lo=10, result 100 -> alarm0 = 1; win_len=0 -> a 1-cycle window with no hang.
